display_source_scheduler: RTL

Time-shares the four-digit seven-segment display between up to four data sources (e.g. MIDI note/tempo, internal ADC, PWM ADC, R2R ADC). It rotates through the valid sources on a dwell timer and honours a manual switch override and one-shot alert overrides. It presents one registered 16-bit value, decimal-point mask and enable to the board display block.

---
 rtl/display_source_scheduler.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/display_source_scheduler.sv
// Time-shares the seven-segment display between NUM_SRC sources: dwell-timed rotation,
// manual switch override and (with SCHED_ALERT_EN defined) one-shot alert overrides.
module display_source_scheduler #(
  parameter int unsigned NUM_SRC      = 4,
  parameter int unsigned DWELL_CYCLES = 100_000_000,
  parameter int unsigned ALERT_CYCLES = 50_000_000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_SRC-1:0]     src_valid,
  input  logic [16*NUM_SRC-1:0]  src_data,
  input  logic [4*NUM_SRC-1:0]   src_dp,
  input  logic [NUM_SRC-1:0]     src_alert,
  input  logic                   manual_en,
  input  logic [1:0]             manual_sel,
  output logic [15:0]            disp_value,
  output logic [3:0]             disp_dp,
  output logic                   disp_en,
  output logic [1:0]             cur_src,
  output logic [NUM_SRC-1:0]     src_ack
);

  localparam int unsigned DW = $clog2(DWELL_CYCLES);
  localparam logic [DW-1:0] DwellLast = DW'(DWELL_CYCLES - 1);

`ifdef SCHED_ALERT_EN
  typedef enum logic [1:0] {StIdle, StShow, StAlert, StManual} state_e;
  localparam int unsigned AW = $clog2(ALERT_CYCLES);
  localparam logic [AW-1:0] AlertLast = AW'(ALERT_CYCLES - 1);
  logic [AW-1:0] alert_q, alert_d;
  logic [1:0]    saved_q, saved_d;
  logic [2:0]    alert_pick, saved_next;
`else
  typedef enum logic [1:0] {StIdle, StShow, StManual} state_e;
  localparam int unsigned unused_alert_cycles = ALERT_CYCLES;
  logic unused_alert;
  assign unused_alert = ^src_alert;
`endif

  state_e              state_q, state_d;
  logic [DW-1:0]       dwell_q, dwell_d;
  logic [1:0]          src_d;
  logic                en_d, load;
  logic [NUM_SRC-1:0]  ack_d;
  logic [2:0]          lo, nx;
  logic [16*NUM_SRC-1:0] data_sh;
  logic [4*NUM_SRC-1:0]  dp_sh;

  function automatic logic bit_of(input logic [NUM_SRC-1:0] v, input logic [1:0] i);
    logic [NUM_SRC-1:0] s;
    s = v >> i;
    return s[0];
  endfunction

  // {found, index} of the lowest set bit
  function automatic logic [2:0] lowest_set(input logic [NUM_SRC-1:0] v);
    logic [NUM_SRC-1:0] s;
    logic [2:0] r;
    r = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      s = v >> i;
      if (s[0]) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

  // {found, index} of the first set bit after cur, wrapping; cur itself is checked last
  function automatic logic [2:0] next_set(input logic [1:0] cur, input logic [NUM_SRC-1:0] v);
    logic [NUM_SRC-1:0] s;
    logic [2:0] r;
    int idx;
    r = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      idx = (int'(cur) + k) % int'(NUM_SRC);
      s = v >> idx;
      if (s[0]) r = {1'b1, idx[1:0]};
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    src_d   = cur_src;
    dwell_d = dwell_q;
    en_d    = disp_en;
    lo      = lowest_set(src_valid);
    nx      = next_set(cur_src, src_valid);
`ifdef SCHED_ALERT_EN
    alert_d    = alert_q;
    saved_d    = saved_q;
    alert_pick = lowest_set(src_alert);
    saved_next = next_set(saved_q, src_valid);
`endif
    if (manual_en) begin
      state_d = StManual;
      src_d   = manual_sel;
      en_d    = 32'(manual_sel) < NUM_SRC;
      dwell_d = '0;
`ifdef SCHED_ALERT_EN
      alert_d = '0;
`endif
    end else if (state_q == StManual) begin
      dwell_d = '0;
      if (bit_of(src_valid, manual_sel)) begin
        state_d = StShow;
        src_d   = manual_sel;
        en_d    = 1'b1;
      end else if (lo[2]) begin
        state_d = StShow;
        src_d   = lo[1:0];
        en_d    = 1'b1;
      end else begin
        state_d = StIdle;
        en_d    = 1'b0;
      end
`ifdef SCHED_ALERT_EN
    end else if (|src_alert) begin
      // Retargeting during an alert keeps the original pre-alert index
      if (state_q != StAlert) saved_d = cur_src;
      state_d = StAlert;
      src_d   = alert_pick[1:0];
      alert_d = '0;
      dwell_d = '0;
      en_d    = 1'b1;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          en_d = 1'b0;
          if (lo[2]) begin
            state_d = StShow;
            src_d   = lo[1:0];
            dwell_d = '0;
            en_d    = 1'b1;
          end
        end
        StShow: begin
          if (!bit_of(src_valid, cur_src)) begin
            dwell_d = '0;
            if (nx[2]) begin
              src_d = nx[1:0];
            end else begin
              state_d = StIdle;
              en_d    = 1'b0;
            end
          end else if (dwell_q == DwellLast) begin
            dwell_d = '0;
            src_d   = nx[1:0];
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end
`ifdef SCHED_ALERT_EN
        StAlert: begin
          if (alert_q == AlertLast) begin
            alert_d = '0;
            dwell_d = '0;
            if (bit_of(src_valid, saved_q)) begin
              state_d = StShow;
              src_d   = saved_q;
            end else if (saved_next[2]) begin
              state_d = StShow;
              src_d   = saved_next[1:0];
            end else begin
              state_d = StIdle;
              en_d    = 1'b0;
            end
          end else begin
            alert_d = alert_q + 1'b1;
          end
        end
`endif
        default: begin
          state_d = StIdle;
          en_d    = 1'b0;
        end
      endcase
    end

    // Ack whenever a source newly appears on an enabled display
    ack_d = '0;
    if (en_d && (!disp_en || src_d != cur_src)) ack_d = {{(NUM_SRC-1){1'b0}}, 1'b1} << src_d;

`ifdef SCHED_ALERT_EN
    load = en_d && (bit_of(src_valid, src_d) || state_d == StAlert);
`else
    load = en_d && bit_of(src_valid, src_d);
`endif
    data_sh = src_data >> (16 * int'(src_d));
    dp_sh   = src_dp >> (4 * int'(src_d));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      dwell_q    <= '0;
      cur_src    <= '0;
      disp_en    <= 1'b0;
      disp_value <= '0;
      disp_dp    <= '0;
      src_ack    <= '0;
`ifdef SCHED_ALERT_EN
      alert_q    <= '0;
      saved_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      cur_src <= src_d;
      disp_en <= en_d;
      src_ack <= ack_d;
      if (load) begin
        disp_value <= data_sh[15:0];
        disp_dp    <= dp_sh[3:0];
      end
`ifdef SCHED_ALERT_EN
      alert_q <= alert_d;
      saved_q <= saved_d;
`endif
    end
  end

endmodule
